// File: rtl/readmemh_loader_pkg.sv
`default_nettype none
// ============================================================================
// Package  : readmemh_loader_pkg
// Summary  : Shared types and ASCII constants for the readmemh text-stream
//            loader: FSM states, error codes, character classes.
// Config   : LOADER_COMMENT_EN - when defined, the SLASH and COMMENT states
//            exist and '//' comments are recognised.
// Revision : 1.0 - initial release
// ============================================================================
package readmemh_loader_pkg;

    // Parser states; the comment states only exist when comments are enabled
    typedef enum logic [2:0] {
        ST_SEP     = 3'd0,
        ST_DATA    = 3'd1,
        ST_ADDR    = 3'd2,
`ifdef LOADER_COMMENT_EN
        ST_SLASH   = 3'd3,
        ST_COMMENT = 3'd4,
`endif
        ST_ERROR   = 3'd5
    } state_e;

    // Sticky error code reported on the err port
    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BADCHAR = 2'd1,
        ERR_DIGITS  = 2'd2,
        ERR_ADDR    = 2'd3
    } err_e;

    // Character class produced by the byte decoder
    typedef enum logic [2:0] {
        CLS_DIGIT = 3'd0,
        CLS_SEP   = 3'd1,
        CLS_UNDER = 3'd2,
        CLS_AT    = 3'd3,
        CLS_SLASH = 3'd4,
        CLS_BAD   = 3'd5
    } cls_e;

    localparam logic [7:0] c_ascii_sp    = 8'h20;
    localparam logic [7:0] c_ascii_ht    = 8'h09;
    localparam logic [7:0] c_ascii_lf    = 8'h0A;
    localparam logic [7:0] c_ascii_cr    = 8'h0D;
    localparam logic [7:0] c_ascii_at    = 8'h40;
    localparam logic [7:0] c_ascii_slash = 8'h2F;
    localparam logic [7:0] c_ascii_under = 8'h5F;

    // Larger of two elaboration-time integers
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : readmemh_loader_pkg
`default_nettype wire

// File: rtl/hex_char_decode.sv
`default_nettype none
// ============================================================================
// Module   : hex_char_decode
// Summary  : Combinational classifier for one ASCII byte: returns the hex
//            nibble value and the character class used by the loader FSM.
// Config   : none (the slash class is always reported; the loader decides
//            whether it is meaningful).
// Revision : 1.0 - initial release
// ============================================================================
module hex_char_decode
    import readmemh_loader_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic [3:0] nib_o,
    output cls_e       cls_o
);

    // Map the byte to a nibble and class; non-digits return nibble 0
    always_comb begin
        nib_o = 4'h0;
        cls_o = CLS_BAD;
        if (byte_i >= 8'h30 && byte_i <= 8'h39) begin
            nib_o = byte_i[3:0];
            cls_o = CLS_DIGIT;
        end else if ((byte_i >= 8'h61 && byte_i <= 8'h66) ||
                     (byte_i >= 8'h41 && byte_i <= 8'h46)) begin
            // 'a'/'A' have low nibble 1, so adding 9 yields 10..15
            nib_o = byte_i[3:0] + 4'd9;
            cls_o = CLS_DIGIT;
        end else begin
            case (byte_i)
                c_ascii_sp, c_ascii_ht, c_ascii_lf, c_ascii_cr: cls_o = CLS_SEP;
                c_ascii_under:                                  cls_o = CLS_UNDER;
                c_ascii_at:                                     cls_o = CLS_AT;
                c_ascii_slash:                                  cls_o = CLS_SLASH;
                default:                                        cls_o = CLS_BAD;
            endcase
        end
    end

endmodule : hex_char_decode
`default_nettype wire

// File: rtl/readmemh_stream_loader.sv
`default_nettype none
// ============================================================================
// Module   : readmemh_stream_loader
// Summary  : Parses a readmemh-format ASCII byte stream (hex words, '@'
//            address directives, separators, '_' spacers, '//' comments) and
//            writes decoded words through a registered memory write port.
//            Errors are reported with a sticky 2-bit code.
// Config   : LOADER_COMMENT_EN - defined: '//' comments to end of line are
//            skipped. Undefined: '/' is a bad character everywhere.
// Revision : 1.0 - initial release
// ============================================================================
module readmemh_stream_loader
    import readmemh_loader_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk_loader,
    input  logic              rst_loader,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              done,
    output logic [1:0]        err,
    output logic [ADDR_W:0]   word_count
);

    localparam int ND     = (DATA_W + 3) / 4;
    localparam int NA     = (ADDR_W + 3) / 4;
    localparam int MAXD   = max_int(ND, NA);
    localparam int ACC_W  = 4 * MAXD;
    localparam int DCNT_W = $clog2(MAXD + 1);

    state_e              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic [ADDR_W:0]     addr_q, addr_d;      // extra MSB flags a wrapped counter
    logic [ADDR_W:0]     wc_q, wc_d, wc_base;
    err_e                err_q, err_d;
    logic                first_q, first_d;    // next accepted byte opens a stream
    logic                rdy_q;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                done_q, done_d;

    logic [3:0]          w_nib;
    cls_e                w_cls;
    logic                w_accept;
    logic                w_addr_ovf;
    logic                w_is_term;
    state_e              w_term_st;
    logic                w_write;
    logic                w_fail;
    err_e                w_code;

    hex_char_decode u_decode (
        .byte_i (in_data),
        .nib_o  (w_nib),
        .cls_o  (w_cls)
    );

    assign w_accept = in_valid && in_ready;

    // A parsed address needs more than ADDR_W bits only if the digit field is wider
    generate
        if (ACC_W > ADDR_W) begin : g_addr_ovf
            assign w_addr_ovf = |acc_q[ACC_W-1:ADDR_W];
        end else begin : g_no_addr_ovf
            assign w_addr_ovf = 1'b0;
        end
    endgenerate

    // Token terminators and the state each one leads to
    always_comb begin
        w_is_term = (w_cls == CLS_SEP);
        w_term_st = ST_SEP;
`ifdef LOADER_COMMENT_EN
        if (w_cls == CLS_SLASH) begin
            w_is_term = 1'b1;
            w_term_st = ST_SLASH;
        end
`endif
    end

    // Next-state, accumulator, address and write-port computation
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        dcnt_d    = dcnt_q;
        addr_d    = addr_q;
        wc_base   = wc_q;
        wc_d      = wc_q;
        err_d     = err_q;
        first_d   = first_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        w_write   = 1'b0;
        w_fail    = 1'b0;
        w_code    = ERR_NONE;

        if (w_accept) begin
            if (first_q) begin
                wc_base = '0;
                err_d   = ERR_NONE;
            end
            wc_d    = wc_base;
            first_d = in_last;

            case (state_q)
                ST_SEP: begin
                    if (w_cls == CLS_DIGIT) begin
                        state_d = ST_DATA;
                        acc_d   = ACC_W'(w_nib);
                        dcnt_d  = DCNT_W'(1);
                    end else if (w_cls == CLS_AT) begin
                        state_d = ST_ADDR;
                        acc_d   = '0;
                        dcnt_d  = '0;
                    end else if (w_is_term) begin
                        state_d = w_term_st;
                    end else begin
                        w_fail = 1'b1;
                        w_code = ERR_BADCHAR;
                    end
                end
                ST_DATA: begin
                    if (w_cls == CLS_DIGIT) begin
                        if (dcnt_q == DCNT_W'(ND)) begin
                            w_fail = 1'b1;
                            w_code = ERR_DIGITS;
                        end else begin
                            acc_d  = {acc_q[ACC_W-5:0], w_nib};
                            dcnt_d = dcnt_q + 1'b1;
                        end
                    end else if (w_cls == CLS_UNDER) begin
                        state_d = ST_DATA;
                    end else if (w_is_term) begin
                        w_write = 1'b1;
                        state_d = w_term_st;
                    end else begin
                        w_fail = 1'b1;
                        w_code = ERR_BADCHAR;
                    end
                end
                ST_ADDR: begin
                    if (w_cls == CLS_DIGIT) begin
                        if (dcnt_q == DCNT_W'(NA)) begin
                            w_fail = 1'b1;
                            w_code = ERR_DIGITS;
                        end else begin
                            acc_d  = {acc_q[ACC_W-5:0], w_nib};
                            dcnt_d = dcnt_q + 1'b1;
                        end
                    end else if (w_is_term && dcnt_q != '0) begin
                        if (w_addr_ovf) begin
                            w_fail = 1'b1;
                            w_code = ERR_ADDR;
                        end else begin
                            addr_d  = {1'b0, acc_q[ADDR_W-1:0]};
                            state_d = w_term_st;
                        end
                    end else begin
                        w_fail = 1'b1;
                        w_code = ERR_BADCHAR;
                    end
                end
`ifdef LOADER_COMMENT_EN
                ST_SLASH: begin
                    if (w_cls == CLS_SLASH) begin
                        state_d = ST_COMMENT;
                    end else begin
                        w_fail = 1'b1;
                        w_code = ERR_BADCHAR;
                    end
                end
                ST_COMMENT: begin
                    if (in_data == c_ascii_lf) begin
                        state_d = ST_SEP;
                    end
                end
`endif
                default: begin
                    state_d = ST_ERROR;
                end
            endcase

            // End of stream: flush a pending word, reject unfinished tokens
            if (in_last && !w_fail && state_q != ST_ERROR) begin
                if (state_d == ST_DATA) begin
                    if (w_cls == CLS_UNDER) begin
                        w_fail = 1'b1;
                        w_code = ERR_BADCHAR;
                    end else begin
                        w_write = 1'b1;
                    end
                end else if (state_d != ST_SEP
`ifdef LOADER_COMMENT_EN
                             && state_d != ST_COMMENT
`endif
                            ) begin
                    w_fail = 1'b1;
                    w_code = ERR_BADCHAR;
                end
            end

            // A word aimed past the top of memory is dropped and flagged
            if (w_write) begin
                if (addr_q[ADDR_W]) begin
                    w_fail = 1'b1;
                    w_code = ERR_ADDR;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q[ADDR_W-1:0];
                    wr_data_d = acc_d[DATA_W-1:0];
                    addr_d    = addr_q + 1'b1;
                    wc_d      = wc_base + 1'b1;
                end
            end

            if (w_fail) begin
                state_d = ST_ERROR;
                err_d   = w_code;
            end

            if (in_last) begin
                done_d  = 1'b1;
                state_d = ST_SEP;
                addr_d  = '0;
                acc_d   = '0;
                dcnt_d  = '0;
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_loader) begin
        if (rst_loader) begin
            state_q   <= ST_SEP;
            acc_q     <= '0;
            dcnt_q    <= '0;
            addr_q    <= '0;
            wc_q      <= '0;
            err_q     <= ERR_NONE;
            first_q   <= 1'b1;
            rdy_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            dcnt_q    <= dcnt_d;
            addr_q    <= addr_d;
            wc_q      <= wc_d;
            err_q     <= err_d;
            first_q   <= first_d;
            rdy_q     <= 1'b1;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
        end
    end

    // rdy_q lags reset by one cycle; gating with reset covers the reset cycle itself
    assign in_ready   = rdy_q && !rst_loader;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign done       = done_q;
    assign err        = err_q;
    assign word_count = wc_q;

endmodule : readmemh_stream_loader
`default_nettype wire

// File: tb/tb_readmemh_stream_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_readmemh_stream_loader
// Summary  : Directed scoreboard bench for readmemh_stream_loader. Stimulus
//            pushes expected writes and end-of-stream results; a monitor
//            pops and compares whenever the DUT writes or pulses done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_readmemh_stream_loader;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;

    logic              clk_loader;
    logic              rst_loader;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              done;
    logic [1:0]        err;
    logic [ADDR_W:0]   word_count;

    readmemh_stream_loader #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk_loader (clk_loader),
        .rst_loader (rst_loader),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    initial clk_loader = 1'b0;
    always #5 clk_loader = ~clk_loader;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    typedef struct {
        logic [1:0]      e;
        logic [ADDR_W:0] wc;
        logic            wr;
    } dn_t;

    wr_t wq[$];
    dn_t dq[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic exp_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_t x;
        x.a = a;
        x.d = d;
        wq.push_back(x);
    endtask

    task automatic exp_done(input logic [1:0] e, input logic [ADDR_W:0] wc, input logic wr);
        dn_t x;
        x.e  = e;
        x.wc = wc;
        x.wr = wr;
        dq.push_back(x);
    endtask

    // Present one byte; returns #1 after the edge that accepted it
    task automatic send(input logic [7:0] b, input logic last);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk_loader);
            #1;
            t++;
        end
        if (t >= 50) chk("ready_timeout", in_ready, 1);
        in_data  = b;
        in_valid = 1'b1;
        in_last  = last;
        @(posedge clk_loader);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input logic last);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i], last && (i == s.len() - 1));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_loader);
        #1;
    endtask

    // Scoreboard monitor: sampled on the falling edge, away from register updates
    always @(negedge clk_loader) begin : mon
        wr_t ew;
        dn_t ed;
        if (wr_en) begin
            chk("wr_expected", (wq.size() > 0), 1);
            if (wq.size() > 0) begin
                ew = wq.pop_front();
                chk("wr_addr", wr_addr, ew.a);
                chk("wr_data", wr_data, ew.d);
            end
        end
        if (done) begin
            chk("done_expected", (dq.size() > 0), 1);
            if (dq.size() > 0) begin
                ed = dq.pop_front();
                chk("done_err", err, ed.e);
                chk("done_word_count", word_count, ed.wc);
                chk("done_with_write", wr_en, ed.wr);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        rst_loader = 1'b1;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        in_data    = 8'h00;
        idle(3);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_word_count", word_count, 0);
        rst_loader = 1'b0;
        chk("ready_cycle_after_rst", in_ready, 0);
        idle(1);
        chk("ready_after_rst", in_ready, 1);

        // Plain data words with flush on the last byte
        exp_wr(8'h00, 16'h0012);
        exp_wr(8'h01, 16'h0034);
        exp_wr(8'h02, 16'h0056);
        exp_done(2'd0, 9'd3, 1'b1);
        send_str("12 34\n56", 1'b1);
        idle(3);
        chk("t1_word_count", word_count, 3);
        chk("t1_err", err, 0);

        // Address directive, '_' spacer, full-width word
        exp_wr(8'h1A, 16'hABCD);
        exp_wr(8'h1B, 16'hFFFF);
        exp_done(2'd0, 9'd2, 1'b1);
        send_str("@1A ab_cd FFFF", 1'b1);
        idle(3);

        // Too many data digits
        exp_done(2'd2, 9'd0, 1'b0);
        send("1", 1'b0);
        chk("t3_wc_cleared", word_count, 0);
        send_str("234", 1'b0);
        chk("t3_err_before", err, 0);
        send("5", 1'b0);
        chk("t3_err_digits", err, 2);
        chk("t3_no_write", wr_en, 0);
        send_str(" 7", 1'b1);
        idle(3);
        chk("t3_err_held", err, 2);

        // Address counter wrap past the top of memory
        exp_wr(8'hFF, 16'h0001);
        exp_done(2'd3, 9'd1, 1'b0);
        send("@", 1'b0);
        chk("t4_err_cleared", err, 0);
        send_str("FF 1 2", 1'b1);
        idle(3);
        chk("t4_err_addr", err, 3);

        // Comment handling depends on build configuration
`ifdef LOADER_COMMENT_EN
        exp_wr(8'h00, 16'h0001);
        exp_wr(8'h01, 16'h0002);
        exp_done(2'd0, 9'd2, 1'b1);
        send("1", 1'b0);
        send("/", 1'b0);
        chk("t5_err_slash", err, 0);
`else
        exp_done(2'd1, 9'd0, 1'b0);
        send("1", 1'b0);
        send("/", 1'b0);
        chk("t5_err_slash", err, 1);
`endif
        send_str("/x 9\n2", 1'b1);
        idle(3);

        // Too many address digits
        exp_done(2'd2, 9'd0, 1'b0);
        send_str("@123 5", 1'b1);
        idle(3);

        // Trailing '_' on the last byte
        exp_done(2'd1, 9'd0, 1'b0);
        send_str("4_", 1'b1);
        idle(3);

        // '@' followed directly by a separator
        exp_done(2'd1, 9'd0, 1'b0);
        send_str("@ 5", 1'b1);
        idle(3);
        chk("t9_err_bad", err, 1);

        // Reset mid-token discards the partial word
        send_str("AB", 1'b0);
        rst_loader = 1'b1;
        idle(2);
        chk("t6_rst_wr_en", wr_en, 0);
        chk("t6_rst_err", err, 0);
        chk("t6_rst_wc", word_count, 0);
        chk("t6_rst_wr_addr", wr_addr, 0);
        chk("t6_rst_wr_data", wr_data, 0);
        rst_loader = 1'b0;
        idle(1);
        exp_wr(8'h00, 16'h0007);
        exp_done(2'd0, 9'd1, 1'b1);
        send("7", 1'b1);
        idle(5);

        chk("writes_outstanding", wq.size(), 0);
        chk("dones_outstanding", dq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_readmemh_stream_loader
`default_nettype wire
